phase_sincos_gen: RTL and testbench

- Converts the phase stream produced by the search-angle generator (`dat_gen`) into cosine/sine reference samples, one per cycle, using a fully pipelined CORDIC.
- Sits directly downstream of `dat_gen` and feeds the reference-correlation stage.
- Tags every output with its index inside the current capture frame and flags the last sample of each frame.

---
 rtl/phase_sincos_pkg.sv | 58 +++++
 rtl/phase_sincos_gen_cordic_stage.sv | 52 +++++
 rtl/phase_sincos_gen.sv | 142 ++++++++++++++
 tb/tb_phase_sincos_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/phase_sincos_pkg.sv
// Shared constants and types for phase_sincos_gen: phase type, pi constants,
// CORDIC arctangent table (Q3.45) and gain reciprocal.
package phase_sincos_pkg;

    typedef logic signed [47:0] phase_t;

    typedef struct packed {
        logic [8:0] idx;
        logic       last;
        logic       neg;
    } tag_t;

    // atan(1/n) in Q60 via its Taylor series; converges for n >= 2.
    function automatic logic [63:0] atan_inv_q60(input logic [63:0] n);
        logic [63:0] term;
        logic [63:0] sum;
        term = 64'h1000_0000_0000_0000 / n;
        sum  = '0;
        for (int unsigned k = 0; k < 64; k++) begin
            if (k[0])
                sum = sum - term / 64'(2 * k + 1);
            else
                sum = sum + term / 64'(2 * k + 1);
            term = term / (n * n);
        end
        return sum;
    endfunction

    function automatic logic [63:0] q60_to_q45(input logic [63:0] v);
        return (v + 64'd16384) >> 15;
    endfunction

    // Machin: pi = 16 atan(1/5) - 4 atan(1/239)
    localparam logic [63:0] PI_Q60 = 64'd16 * atan_inv_q60(64'd5) - 64'd4 * atan_inv_q60(64'd239);
    localparam phase_t PI_Q45      = phase_t'(q60_to_q45(PI_Q60));
    localparam phase_t HALF_PI_Q45 = phase_t'(q60_to_q45(PI_Q60 >> 1));

    function automatic phase_t atan_q45(input int unsigned i);
        if (i == 0)
            return phase_t'(q60_to_q45(PI_Q60 >> 2));
        return phase_t'(q60_to_q45(atan_inv_q60(64'd1 << i)));
    endfunction

    localparam phase_t ATAN_Q45 [0:31] = '{
        atan_q45(0),  atan_q45(1),  atan_q45(2),  atan_q45(3),
        atan_q45(4),  atan_q45(5),  atan_q45(6),  atan_q45(7),
        atan_q45(8),  atan_q45(9),  atan_q45(10), atan_q45(11),
        atan_q45(12), atan_q45(13), atan_q45(14), atan_q45(15),
        atan_q45(16), atan_q45(17), atan_q45(18), atan_q45(19),
        atan_q45(20), atan_q45(21), atan_q45(22), atan_q45(23),
        atan_q45(24), atan_q45(25), atan_q45(26), atan_q45(27),
        atan_q45(28), atan_q45(29), atan_q45(30), atan_q45(31)
    };

    // 0.607252935 in Q0.32; the top rescales it to the x datapath width.
    localparam logic [31:0] K_INV_Q = 32'h9B74_EDA8;

endpackage

// File: rtl/phase_sincos_gen_cordic_stage.sv
// One registered CORDIC micro-rotation (rotation mode); shift amount and
// arctangent constant are parameters.
module cordic_stage
    import phase_sincos_pkg::*;
#(
    parameter int unsigned XW    = 28,
    parameter int unsigned SHIFT = 0,
    parameter phase_t      ATAN  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid_in,
    input  logic signed [XW-1:0] x_in,
    input  logic signed [XW-1:0] y_in,
    input  phase_t               z_in,
    input  tag_t                 tag_in,
    output logic                 valid_out,
    output logic signed [XW-1:0] x_out,
    output logic signed [XW-1:0] y_out,
    output phase_t               z_out,
    output tag_t                 tag_out
);

    logic signed [XW-1:0] x_sh;
    logic signed [XW-1:0] y_sh;

    assign x_sh = x_in >>> SHIFT;
    assign y_sh = y_in >>> SHIFT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_out <= 1'b0;
            x_out     <= '0;
            y_out     <= '0;
            z_out     <= '0;
            tag_out   <= '0;
        end else begin
            valid_out <= valid_in;
            tag_out   <= tag_in;
            if (z_in[47]) begin
                x_out <= x_in + y_sh;
                y_out <= y_in - x_sh;
                z_out <= z_in + ATAN;
            end else begin
                x_out <= x_in - y_sh;
                y_out <= y_in + x_sh;
                z_out <= z_in - ATAN;
            end
        end
    end

endmodule

// File: rtl/phase_sincos_gen.sv
// Pipelined phase -> cos/sin CORDIC with frame indexing and range flag.
// Optional macro SINCOS_ROUND_EN: round half up instead of truncating at output.
module phase_sincos_gen
    import phase_sincos_pkg::*;
#(
    parameter int unsigned STAGES = 24,
    parameter int unsigned OUT_W  = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [47:0]      angle_in,
    input  logic             angle_valid,
    input  logic             frame_start,
    input  logic [8:0]       frame_len,
    output logic [OUT_W-1:0] cos_out,
    output logic [OUT_W-1:0] sin_out,
    output logic             out_valid,
    output logic [8:0]       out_idx,
    output logic             out_last,
    output logic             range_err
);

    localparam int unsigned XW   = OUT_W + 4;
    localparam int unsigned DROP = 2;   // x/y carry OUT_W+1 fraction bits, outputs OUT_W-1
    localparam logic [63:0] K_SCALED = ((64'(K_INV_Q) << (OUT_W + 1)) + 64'h8000_0000) >> 32;
    localparam logic signed [XW-1:0] X0 = XW'(K_SCALED);
    localparam logic signed [XW:0] SAT_MAX = (XW + 1)'((64'd1 << (OUT_W - 1)) - 64'd1);

    logic [8:0] idx_cnt, len_q, idx_now, len_now;
    logic       last_now, over_pos, over_neg, fold_neg;
    phase_t     ang, ang_cl, fold_z;

    logic       fold_vld_q;
    phase_t     fold_z_q;
    tag_t       fold_tag_q;

    logic                 vs   [0:STAGES];
    logic signed [XW-1:0] xs   [0:STAGES];
    logic signed [XW-1:0] ys   [0:STAGES];
    phase_t               zs   [0:STAGES];
    tag_t                 tags [0:STAGES];

    always_comb begin
        idx_now  = frame_start ? '0 : idx_cnt;
        len_now  = frame_start ? frame_len : len_q;
        last_now = (len_now != '0) && (idx_now == len_now - 9'd1);
        ang      = phase_t'(angle_in);
        over_pos = ang > PI_Q45;
        over_neg = ang < -PI_Q45;
        ang_cl   = over_pos ? PI_Q45 : (over_neg ? -PI_Q45 : ang);
        fold_z   = ang_cl;
        fold_neg = 1'b0;
        if (ang_cl > HALF_PI_Q45) begin
            fold_z   = ang_cl - PI_Q45;
            fold_neg = 1'b1;
        end else if (ang_cl < -HALF_PI_Q45) begin
            fold_z   = ang_cl + PI_Q45;
            fold_neg = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_cnt    <= '0;
            len_q      <= '0;
            range_err  <= 1'b0;
            fold_vld_q <= 1'b0;
            fold_z_q   <= '0;
            fold_tag_q <= '0;
        end else begin
            if (frame_start)
                len_q <= frame_len;
            if (angle_valid)
                idx_cnt <= idx_now + 9'd1;
            else if (frame_start)
                idx_cnt <= '0;
            if (angle_valid && (over_pos || over_neg))
                range_err <= 1'b1;
            fold_vld_q <= angle_valid;
            fold_z_q   <= fold_z;
            fold_tag_q <= '{idx: idx_now, last: last_now, neg: fold_neg};
        end
    end

    assign vs[0]   = fold_vld_q;
    assign xs[0]   = X0;
    assign ys[0]   = '0;
    assign zs[0]   = fold_z_q;
    assign tags[0] = fold_tag_q;

    for (genvar i = 0; i < STAGES; i++) begin : g_rot
        cordic_stage #(
            .XW   (XW),
            .SHIFT(i),
            .ATAN (ATAN_Q45[i])
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .valid_in (vs[i]),
            .x_in     (xs[i]),
            .y_in     (ys[i]),
            .z_in     (zs[i]),
            .tag_in   (tags[i]),
            .valid_out(vs[i+1]),
            .x_out    (xs[i+1]),
            .y_out    (ys[i+1]),
            .z_out    (zs[i+1]),
            .tag_out  (tags[i+1])
        );
    end

    function automatic logic [OUT_W-1:0] reduce(input logic signed [XW-1:0] v);
        logic signed [XW:0] t;
        t = {v[XW-1], v};
`ifdef SINCOS_ROUND_EN
        t = t + (XW + 1)'(1 << (DROP - 1));
`endif
        t = t >>> DROP;
        if (t > SAT_MAX)
            t = SAT_MAX;
        else if (t < -SAT_MAX)
            t = -SAT_MAX;
        return t[OUT_W-1:0];
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cos_out   <= '0;
            sin_out   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            out_last  <= 1'b0;
        end else begin
            cos_out   <= reduce(tags[STAGES].neg ? -xs[STAGES] : xs[STAGES]);
            sin_out   <= reduce(tags[STAGES].neg ? -ys[STAGES] : ys[STAGES]);
            out_valid <= vs[STAGES];
            out_idx   <= tags[STAGES].idx;
            out_last  <= vs[STAGES] && tags[STAGES].last;
        end
    end

endmodule

// File: tb/tb_phase_sincos_gen.sv
// Randomized bench for phase_sincos_gen against a real-arithmetic sin/cos
// model with a frame-index scoreboard.
`timescale 1ns/1ps
module tb_phase_sincos_gen;

    localparam int     STAGES = 24;
    localparam int     OUT_W  = 24;
    localparam int     LAT    = STAGES + 2;
    localparam real    PI_R   = 3.14159265358979323846;
    localparam real    Q45    = 35184372088832.0;
    localparam longint MAXV   = (longint'(1) << (OUT_W - 1)) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [47:0]      angle_in = '0;
    logic             angle_valid = 1'b0;
    logic             frame_start = 1'b0;
    logic [8:0]       frame_len = '0;
    logic [OUT_W-1:0] cos_out, sin_out;
    logic             out_valid, out_last, range_err;
    logic [8:0]       out_idx;

    phase_sincos_gen #(.STAGES(STAGES), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .angle_in(angle_in), .angle_valid(angle_valid),
        .frame_start(frame_start), .frame_len(frame_len), .cos_out(cos_out),
        .sin_out(sin_out), .out_valid(out_valid), .out_idx(out_idx),
        .out_last(out_last), .range_err(range_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint due;
        int     idx;
        bit     last;
        longint c;
        longint s;
    } exp_t;

    exp_t   exp_q[$];
    exp_t   e;
    longint cyc = 0;
    int     n_cmp = 0, n_err = 0;
    int     m_cnt = 0, m_len = 0;
    bit     m_rerr = 1'b0;
    bit     due_now;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint want, input longint tol = 0);
        n_cmp++;
        if (got - want > tol || want - got > tol) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (tol %0d) at cycle %0d", tag, got, want, tol, cyc);
        end
    endtask

    function automatic longint to_code(input real v);
        longint r;
        r = longint'(v * (2.0 ** (OUT_W - 1)));
        if (r > MAXV) r = MAXV;
        if (r < -MAXV) r = -MAXV;
        return r;
    endfunction

    function automatic longint rad(input real th);
        return longint'(th * Q45);
    endfunction

    function automatic longint rnd_angle();
        return rad((real'($urandom_range(0, 2000000)) / 1000000.0 - 1.0) * (PI_R - 0.001));
    endfunction

    task automatic send(input bit v, input longint a, input bit fs, input int flen);
        real th;
        int  idx, len;
        angle_valid = v;
        angle_in    = a[47:0];
        frame_start = fs;
        frame_len   = flen[8:0];
        idx = fs ? 0 : m_cnt;
        len = fs ? flen : m_len;
        if (v) begin
            th = real'(a) / Q45;
            if (th > PI_R) begin th = PI_R; m_rerr = 1'b1; end
            else if (th < -PI_R) begin th = -PI_R; m_rerr = 1'b1; end
            exp_q.push_back('{cyc + LAT, idx, (len != 0) && (idx == len - 1),
                              to_code($cos(th)), to_code($sin(th))});
            m_cnt = (idx + 1) % 512;
        end else if (fs) begin
            m_cnt = 0;
        end
        m_len = len;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(1'b0, 0, 1'b0, 0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            due_now = (exp_q.size() != 0) && (exp_q[0].due == cyc);
            if (out_valid || due_now) begin
                check("out_valid", out_valid, due_now);
                if (due_now) begin
                    e = exp_q.pop_front();
                    if (out_valid) begin
                        check("out_idx", out_idx, e.idx);
                        check("out_last", out_last, e.last);
                        check("cos_out", $signed(cos_out), e.c, 4);
                        check("sin_out", $signed(sin_out), e.s, 4);
                    end
                end
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_cos", cos_out, 0);
        check("rst_sin", sin_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        check("rst_range_err", range_err, 0);
        rst = 1'b0;

        send(1'b1, 0, 1'b0, 0);
        send(1'b1, rad(PI_R / 2.0), 1'b0, 0);
        send(1'b1, rad(-0.75 * PI_R), 1'b0, 0);
        idle(LAT + 2);

        send(1'b0, 0, 1'b1, 4);
        for (int i = 0; i < 6; i++) send(1'b1, rnd_angle(), 1'b0, 0);
        idle(3);

        send(1'b1, rnd_angle(), 1'b1, 3);
        idle(2);
        send(1'b1, rnd_angle(), 1'b0, 0);
        idle(2);
        send(1'b1, rnd_angle(), 1'b0, 0);
        idle(LAT + 2);

        for (int i = 0; i < 400; i++)
            send($urandom_range(0, 9) < 7, rnd_angle(), $urandom_range(0, 29) == 0,
                 $urandom_range(0, 12));

        for (int k = 1; k <= 1000; k++)
            send(1'b1, rad(-PI_R + 2.0 * PI_R * real'(k) / 1001.0), 1'b0, 0);
        idle(LAT + 2);
        check("range_err_clear", range_err, m_rerr);

        send(1'b1, rad(3.5), 1'b0, 0);
        idle(2);
        check("range_err_set", range_err, m_rerr);
        send(1'b1, -(longint'(1) << 47), 1'b0, 0);
        send(1'b1, rad(0.3), 1'b0, 0);
        idle(LAT + 2);
        check("range_err_sticky", range_err, m_rerr);

        for (int i = 0; i < 10; i++) send(1'b1, rnd_angle(), 1'b0, 0);
        rst = 1'b1;
        exp_q.delete();
        m_cnt  = 0;
        m_len  = 0;
        m_rerr = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_range_err", range_err, m_rerr);
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(1'b1, rad(1.0), 1'b0, 0);
        idle(LAT + 4);

        for (int i = 0; i < LAT + 8 && exp_q.size() != 0; i++) idle(1);
        check("drain_pending", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
